// File: rtl/mlp_layer_sequencer.sv
// Purpose : sequences one fully-connected MLP layer (SRAM weight/input reads -> MAC -> output write).
// Latency : start in cycle t -> CLEAR at t+1; NUM_INPUTS+3 cycles per neuron; done at t+NUM_NEURONS*(NUM_INPUTS+3)+1.
// Backpr. : none; SRAM and MAC are assumed always ready, abort cancels a running layer.
module mlp_layer_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 9,
    parameter int WEIGHT_BASE = 0,
    parameter int INPUT_BASE  = 256,
    parameter int OUTPUT_BASE = 384,
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int KW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              read_enable,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [ADDR_W-1:0] input_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              write_enable,
    output logic [ADDR_W-1:0] out_addr,
    output logic [NW-1:0]     neuron_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Address arithmetic is done at ADDR_W bits so it wraps naturally.
    localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(WEIGHT_BASE);
    localparam logic [ADDR_W-1:0] I_BASE = ADDR_W'(INPUT_BASE);
    localparam logic [ADDR_W-1:0] O_BASE = ADDR_W'(OUTPUT_BASE);
    localparam logic [ADDR_W-1:0] N_IN   = ADDR_W'(NUM_INPUTS);
    localparam logic [KW-1:0]     K_LAST = KW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0]     N_LAST = NW'(NUM_NEURONS - 1);

    state_t         state, state_nx;
    logic [NW-1:0]  n, n_nx;
    logic [KW-1:0]  k, k_nx;
    logic           running;

    assign running = (state != IDLE);

    // State and loop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n     <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            n     <= n_nx;
            k     <= k_nx;
        end
    end

    // Next state and counter updates; abort overrides every transition.
    always_comb begin
        state_nx = state;
        n_nx     = n;
        k_nx     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR;
                    n_nx     = '0;
                    k_nx     = '0;
                end
            end
            CLEAR: begin
                k_nx     = '0;
                state_nx = FETCH;
            end
            FETCH: begin
                if (k == K_LAST) begin
                    k_nx     = '0;
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            DRAIN: state_nx = WRITE;
            WRITE: begin
                if (n == N_LAST) begin
                    state_nx = DONE;
                end else begin
                    n_nx     = n + 1'b1;
                    state_nx = CLEAR;
                end
            end
            DONE: begin
                n_nx     = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (abort && running) begin
            state_nx = IDLE;
            n_nx     = '0;
            k_nx     = '0;
        end
    end

    // Output decode from registered state; unused addresses are held at 0.
    always_comb begin
        read_enable  = 1'b0;
        weight_addr  = '0;
        input_addr   = '0;
        acc_clear    = 1'b0;
        write_enable = 1'b0;
        out_addr     = '0;
        done         = 1'b0;
        case (state)
            CLEAR: acc_clear = 1'b1;
            FETCH: begin
                read_enable = 1'b1;
                weight_addr = W_BASE + ADDR_W'(n) * N_IN + ADDR_W'(k);
                input_addr  = I_BASE + ADDR_W'(k);
            end
            WRITE: begin
                // An abort in the write cycle suppresses the write itself.
                write_enable = !abort;
                out_addr     = O_BASE + ADDR_W'(n);
            end
            DONE:    done = !abort;
            default: ;
        endcase
    end

    assign busy       = running;
    assign neuron_idx = n;

    // Accumulate enable trails the read strobe by the one-cycle SRAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_en <= 1'b0;
        end else if (abort && running) begin
            acc_en <= 1'b0;
        end else begin
            acc_en <= read_enable;
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Purpose : self-checking bench for mlp_layer_sequencer (4x2 layer plus a 1x1 corner instance).
// Latency : expected traces are cycle-exact, indexed from the cycle start is applied.
// Backpr. : not applicable; inputs are driven on the falling edge, outputs sampled 1ns later.
module tb_mlp_layer_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic start6 = 1'b0, abort6 = 1'b0;

    logic       re, clr, ae, we, ni, busy, done;
    logic [8:0] wa, ia, oa;

    logic       re6, clr6, ae6, we6, ni6, busy6, done6;
    logic [3:0] wa6, ia6, oa6;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mlp_layer_sequencer #(
        .NUM_INPUTS(4), .NUM_NEURONS(2), .ADDR_W(9),
        .WEIGHT_BASE(0), .INPUT_BASE(64), .OUTPUT_BASE(128)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .read_enable(re), .weight_addr(wa), .input_addr(ia),
        .acc_clear(clr), .acc_en(ae), .write_enable(we), .out_addr(oa),
        .neuron_idx(ni), .busy(busy), .done(done)
    );

    mlp_layer_sequencer #(
        .NUM_INPUTS(1), .NUM_NEURONS(1), .ADDR_W(4),
        .WEIGHT_BASE(0), .INPUT_BASE(8), .OUTPUT_BASE(15)
    ) dut6 (
        .clk(clk), .reset(reset), .start(start6), .abort(abort6),
        .read_enable(re6), .weight_addr(wa6), .input_addr(ia6),
        .acc_clear(clr6), .acc_en(ae6), .write_enable(we6), .out_addr(oa6),
        .neuron_idx(ni6), .busy(busy6), .done(done6)
    );

    logic [33:0] obs;
    logic [18:0] obs6;
    assign obs  = {re, wa, ia, clr, ae, we, oa, ni, busy, done};
    assign obs6 = {re6, wa6, ia6, clr6, ae6, we6, oa6, ni6, busy6, done6};

    typedef struct {
        logic        st;
        logic        ab;
        logic [33:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [33:0] mk(input logic r, input logic [8:0] w, input logic [8:0] i,
                                       input logic c, input logic a, input logic wr,
                                       input logic [8:0] o, input logic n, input logic b,
                                       input logic d);
        return {r, w, i, c, a, wr, o, n, b, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        #1;
    endtask

    int done_cnt;
    int act_cnt;

    initial begin
        //           st ab       re wa  ia  clr ae we oa   ni busy done
        tbl[0]  = '{1'b1, 1'b0, mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b0, mk(0, 0, 0,  1, 0, 0, 0,   0, 1, 0)};
        tbl[2]  = '{1'b0, 1'b0, mk(1, 0, 64, 0, 0, 0, 0,   0, 1, 0)};
        tbl[3]  = '{1'b0, 1'b0, mk(1, 1, 65, 0, 1, 0, 0,   0, 1, 0)};
        tbl[4]  = '{1'b0, 1'b0, mk(1, 2, 66, 0, 1, 0, 0,   0, 1, 0)};
        tbl[5]  = '{1'b0, 1'b0, mk(1, 3, 67, 0, 1, 0, 0,   0, 1, 0)};
        tbl[6]  = '{1'b0, 1'b0, mk(0, 0, 0,  0, 1, 0, 0,   0, 1, 0)};
        tbl[7]  = '{1'b0, 1'b0, mk(0, 0, 0,  0, 0, 1, 128, 0, 1, 0)};
        tbl[8]  = '{1'b0, 1'b0, mk(0, 0, 0,  1, 0, 0, 0,   1, 1, 0)};
        tbl[9]  = '{1'b0, 1'b0, mk(1, 4, 64, 0, 0, 0, 0,   1, 1, 0)};
        tbl[10] = '{1'b0, 1'b0, mk(1, 5, 65, 0, 1, 0, 0,   1, 1, 0)};
        tbl[11] = '{1'b0, 1'b0, mk(1, 6, 66, 0, 1, 0, 0,   1, 1, 0)};
        tbl[12] = '{1'b0, 1'b0, mk(1, 7, 67, 0, 1, 0, 0,   1, 1, 0)};
        tbl[13] = '{1'b0, 1'b0, mk(0, 0, 0,  0, 1, 0, 0,   1, 1, 0)};
        tbl[14] = '{1'b0, 1'b0, mk(0, 0, 0,  0, 0, 1, 129, 1, 1, 0)};
        tbl[15] = '{1'b0, 1'b0, mk(0, 0, 0,  0, 0, 0, 0,   1, 1, 1)};
        tbl[16] = '{1'b0, 1'b0, mk(0, 0, 0,  0, 0, 0, 0,   0, 0, 0)};

        // Reset state of both instances.
        #12;
        check("reset_outputs", 64'(obs), 64'd0);
        check("reset_outputs_1x1", 64'(obs6), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        // Full layer trace: addresses, acc_en timing, writes and done.
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].st, tbl[i].ab);
            check($sformatf("layer_cycle_%0d", i), 64'(obs), 64'(tbl[i].exp));
        end

        // Abort during neuron 1 FETCH.
        cyc(1, 0);
        for (int i = 1; i < 10; i++) cyc(0, 0);
        cyc(0, 1);
        check("abort_cycle_fetch_addr", 64'(wa), 64'd5);
        cyc(0, 0);
        check("abort_next_all_idle", 64'(obs), 64'd0);
        act_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0);
            if (we || done || busy || ae) act_cnt++;
        end
        check("abort_no_activity", 64'(act_cnt), 64'd0);
        // start and abort together in IDLE: start wins, restart from neuron 0.
        cyc(1, 1);
        cyc(0, 0);
        check("restart_clear", 64'(obs), 64'(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
        cyc(0, 0);
        check("restart_first_read", 64'(obs), 64'(mk(1, 0, 64, 0, 0, 0, 0, 0, 1, 0)));
        done_cnt = 0;
        for (int i = 3; i <= 15; i++) begin
            cyc(0, 0);
            if (done) begin
                done_cnt++;
                check("restart_done_cycle", 64'(i), 64'd15);
            end
        end
        check("restart_done_count", 64'(done_cnt), 64'd1);
        cyc(0, 0);

        // start held high through a whole layer.
        done_cnt = 0;
        cyc(1, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(1, 0);
            if (done) done_cnt++;
            if (i == 8) check("held_start_neuron1_clear", 64'(obs),
                              64'(mk(0, 0, 0, 1, 0, 0, 0, 1, 1, 0)));
        end
        check("held_start_one_done", 64'(done_cnt), 64'd1);
        cyc(1, 0);
        check("held_start_idle_after_done", 64'(busy), 64'd0);
        cyc(1, 0);
        check("held_start_relaunch", 64'(obs), 64'(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
        cyc(0, 1);
        cyc(0, 0);
        check("abort_in_clear", 64'(obs), 64'd0);

        // Async reset in the WRITE cycle.
        cyc(1, 0);
        for (int i = 1; i <= 7; i++) cyc(0, 0);
        check("pre_reset_write", 64'(we), 64'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'(obs), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        act_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0);
            if (busy || re || we || done || ae || clr) act_cnt++;
        end
        check("post_reset_quiet", 64'(act_cnt), 64'd0);

        // NUM_INPUTS=1, NUM_NEURONS=1, OUTPUT_BASE at the top of a 4-bit space.
        @(negedge clk);
        start6 = 1'b1;
        #1;
        check("n1_idle", 64'(obs6), 64'd0);
        @(negedge clk);
        start6 = 1'b0;
        #1;
        check("n1_clear", 64'(obs6), 64'({1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        check("n1_read", 64'(obs6), 64'({1'b1, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        check("n1_drain", 64'(obs6), 64'({1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        check("n1_write", 64'(obs6), 64'({1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        check("n1_done", 64'(obs6), 64'({1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1}));
        @(negedge clk);
        #1;
        check("n1_back_idle", 64'(obs6), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
